// File: rtl/satatx_crc_pkg.sv
// ---------------------------------------------------------------------------
// satatx_crc_pkg
// Shared SATA link-layer constants used by the TX CRC appender and the RX CRC
// checker: the CRC seed, the CRC-32 generator polynomial, and the TX CRC
// state encoding.
// ---------------------------------------------------------------------------
package satatx_crc_pkg;

    // Seed loaded at reset and at the start of every frame.
    localparam logic [31:0] SATA_CRC_INIT = 32'h5232_5032;

    // CRC-32 generator polynomial (x^32 term implied).
    localparam logic [31:0] SATA_CRC_POLY = 32'h04C1_1DB7;

    // S_DATA: forward payload Dwords; S_CRC: emit the CRC Dword.
    typedef enum logic {
        S_DATA = 1'b0,
        S_CRC  = 1'b1
    } tx_crc_state_t;

endpackage

// File: rtl/sata_crc_dword.sv
// ---------------------------------------------------------------------------
// sata_crc_dword
// Purely combinational single-Dword CRC update. The 32 data bits are shifted
// MSB (bit 31) first into a Galois LFSR built around P_CRC_POLY. There is no
// bit reflection and no final inversion. Shared by the TX and RX CRC blocks.
//
// Ports
//   crc      in  32  current CRC register value
//   data     in  32  Dword to hash
//   crc_next out 32  CRC after hashing all 32 bits of data
// ---------------------------------------------------------------------------
module sata_crc_dword
    import satatx_crc_pkg::*;
#(
    parameter logic [31:0] P_CRC_POLY = SATA_CRC_POLY
) (
    input  logic [31:0] crc,
    input  logic [31:0] data,
    output logic [31:0] crc_next
);

    // stage[k] is the register contents after k data bits have been shifted in.
    logic [31:0] stage [0:32];

    assign stage[0] = crc;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_bit
            logic fb;
            // Feedback is the outgoing MSB combined with the data bit entering now.
            assign fb            = stage[gi][31] ^ data[31-gi];
            assign stage[gi+1]   = {stage[gi][30:0], 1'b0} ^ (fb ? P_CRC_POLY : 32'h0);
        end
    endgenerate

    assign crc_next = stage[32];

endmodule

// File: rtl/satatx_crc.sv
// ---------------------------------------------------------------------------
// satatx_crc
// Appends a CRC-32 Dword to every frame travelling from the transport layer
// to the TX framer. Payload Dwords pass through a single register stage with
// full throughput; after the TLAST Dword is accepted one extra beat carrying
// the CRC (with TLAST set) is emitted, then the CRC is reseeded.
//
// Ports
//   S_AXI_ACLK     in   1   clock
//   S_AXI_ARESETN  in   1   asynchronous active-low reset
//   S_AXIS_TVALID  in   1   payload valid
//   S_AXIS_TREADY  out  1   payload ready (low while the CRC beat is pending)
//   S_AXIS_TDATA   in  32   payload Dword
//   S_AXIS_TLAST   in   1   last payload Dword of the frame
//   M_AXIS_TVALID  out  1   output valid (registered)
//   M_AXIS_TREADY  in   1   downstream ready
//   M_AXIS_TDATA   out 32   payload Dword or CRC (registered)
//   M_AXIS_TLAST   out  1   set only on the CRC beat (registered)
// ---------------------------------------------------------------------------
module satatx_crc
    import satatx_crc_pkg::*;
#(
    parameter logic [31:0] P_CRC_INIT   = SATA_CRC_INIT,
    parameter logic [31:0] P_CRC_POLY   = SATA_CRC_POLY,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST
);

    tx_crc_state_t state_reg, state_next;
    logic [31:0]   crc_reg,    crc_next;
    logic          m_valid_reg, m_valid_next;
    logic [31:0]   m_data_reg,  m_data_next;
    logic          m_last_reg,  m_last_next;

    logic [31:0]   crc_upd;
    logic          out_free;
    logic          s_ready;
    logic          beat_in;

    sata_crc_dword #(
        .P_CRC_POLY (P_CRC_POLY)
    ) u_crc_dword (
        .crc      (crc_reg),
        .data     (S_AXIS_TDATA),
        .crc_next (crc_upd)
    );

    // The output register can take a new beat when it is empty or draining.
    assign out_free = !m_valid_reg || M_AXIS_TREADY;

    // Gating with the reset pin keeps TREADY low for the whole reset interval,
    // not just from the first clock edge.
    assign s_ready  = S_AXI_ARESETN && out_free && (state_reg == S_DATA);
    assign beat_in  = s_ready && S_AXIS_TVALID;

    always_comb begin
        state_next   = state_reg;
        crc_next     = crc_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_last_next  = m_last_reg;

        if (beat_in) begin
            // Payload beat: forward it and fold it into the running CRC.
            m_valid_next = 1'b1;
            m_data_next  = S_AXIS_TDATA;
            m_last_next  = 1'b0;
            crc_next     = crc_upd;
            if (S_AXIS_TLAST) begin
                state_next = S_CRC;
            end
        end else if ((state_reg == S_CRC) && out_free) begin
            // CRC beat: emit the finished CRC and reseed for the next frame.
            m_valid_next = 1'b1;
            m_data_next  = crc_reg;
            m_last_next  = 1'b1;
            crc_next     = P_CRC_INIT;
            state_next   = S_DATA;
        end else if (M_AXIS_TREADY) begin
            m_valid_next = 1'b0;
            if (OPT_LOWPOWER) begin
                m_data_next = 32'h0;
                m_last_next = 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg   <= S_DATA;
            crc_reg     <= P_CRC_INIT;
            m_valid_reg <= 1'b0;
            m_data_reg  <= 32'h0;
            m_last_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            crc_reg     <= crc_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            m_last_reg  <= m_last_next;
        end
    end

    assign S_AXIS_TREADY = s_ready;
    assign M_AXIS_TVALID = m_valid_reg;
    assign M_AXIS_TDATA  = m_data_reg;
    assign M_AXIS_TLAST  = m_last_reg;

endmodule

// File: tb/tb_satatx_crc.sv
// ---------------------------------------------------------------------------
// tb_satatx_crc
// Directed/randomized bench for satatx_crc. Expected output beats come from a
// frame-level model: the CRC is the remainder of GF(2) long division of the
// seeded, 32-bit-augmented message by the generator polynomial.
// ---------------------------------------------------------------------------
module tb_satatx_crc;

    localparam logic [31:0] SEED = 32'h5232_5032;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam int          MAX_CYC = 3000;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        S_AXI_ACLK;
    logic        S_AXI_ARESETN;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;

    int    checks = 0;
    int    errors = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    bit    pending = 0;   // last payload accepted, CRC beat not yet loaded

    satatx_crc dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC as polynomial remainder: (seed * x^L + M(x) * x^32) mod G(x).
    function automatic logic [31:0] model_crc(input logic [31:0] seed, input logic [31:0] words[$]);
        bit          a[$];
        int          len;
        logic [31:0] p;
        logic [31:0] r;
        p   = POLY;
        len = words.size() * 32;
        foreach (words[w])
            for (int b = 31; b >= 0; b--) a.push_back(words[w][b]);
        for (int k = 0; k < 32; k++) a.push_back(1'b0);
        for (int k = 0; k < 32; k++) a[k] = a[k] ^ seed[31-k];
        for (int i = 0; i < len; i++)
            if (a[i])
                for (int j = 0; j < 32; j++) a[i+1+j] = a[i+1+j] ^ p[31-j];
        for (int j = 0; j < 32; j++) r[31-j] = a[len+j];
        return r;
    endfunction

    task automatic add_frame(input logic [31:0] words[$]);
        for (int i = 0; i < words.size(); i++) begin
            in_q.push_back('{d: words[i], l: (i == words.size() - 1)});
            exp_q.push_back('{d: words[i], l: 1'b0});
        end
        exp_q.push_back('{d: model_crc(SEED, words), l: 1'b1});
    endtask

    // Drive in_q and check every consumed output beat against exp_q.
    task automatic run(input int gap_pct, input int rdy_pct, input string tag);
        int          cyc;
        logic        stall;
        logic [31:0] sd;
        logic        sl;
        logic        exp_rdy;
        logic        accept;
        logic        consume;
        logic        free;
        beat_t       e;
        cyc   = 0;
        stall = 1'b0;
        sd    = 32'h0;
        sl    = 1'b0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < MAX_CYC) begin
            @(negedge S_AXI_ACLK);
            cyc++;
            if (stall) begin
                check({tag, " hold valid"}, 32'(M_AXIS_TVALID), 32'd1);
                check({tag, " hold data"},  M_AXIS_TDATA, sd);
                check({tag, " hold last"},  32'(M_AXIS_TLAST), 32'(sl));
            end
            M_AXIS_TREADY = ($urandom_range(99) < rdy_pct);
            if (in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = in_q[0].d;
                S_AXIS_TLAST  = in_q[0].l;
            end else begin
                S_AXIS_TVALID = 1'b0;
                S_AXIS_TDATA  = $urandom;
                S_AXIS_TLAST  = 1'($urandom_range(1));
            end
            #1;
            exp_rdy = (!M_AXIS_TVALID || M_AXIS_TREADY) && !pending;
            check({tag, " s_tready"}, 32'(S_AXIS_TREADY), 32'(exp_rdy));
            accept  = S_AXIS_TVALID && S_AXIS_TREADY;
            consume = M_AXIS_TVALID && M_AXIS_TREADY;
            if (consume) begin
                if (exp_q.size() == 0) begin
                    check({tag, " extra beat"}, 32'(M_AXIS_TVALID), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " data"}, M_AXIS_TDATA, e.d);
                    check({tag, " last"}, 32'(M_AXIS_TLAST), 32'(e.l));
                    $display("%s: beat data=%h last=%0d (exp %h/%0d)", tag, M_AXIS_TDATA, M_AXIS_TLAST, e.d, e.l);
                end
            end
            free = !M_AXIS_TVALID || M_AXIS_TREADY;
            if (pending && free) pending = 1'b0;
            if (accept && in_q.size() > 0) begin
                if (in_q[0].l) pending = 1'b1;
                void'(in_q.pop_front());
            end
            stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            sd    = M_AXIS_TDATA;
            sl    = M_AXIS_TLAST;
        end
        if (cyc >= MAX_CYC)
            check({tag, " timeout beats left"}, 32'(exp_q.size()), 32'd0);
        in_q.delete();
        exp_q.delete();
        @(negedge S_AXI_ACLK);
        S_AXIS_TVALID = 1'b0;
    endtask

    // No stray beats may appear once a sequence has drained.
    task automatic idle(input int n, input string tag);
        M_AXIS_TREADY = 1'b1;
        S_AXIS_TVALID = 1'b0;
        repeat (n) begin
            @(negedge S_AXI_ACLK);
            check({tag, " idle valid"}, 32'(M_AXIS_TVALID), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] q[$];

        S_AXI_ARESETN = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = 32'h0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;

        // Reset state
        #1;
        check("reset valid",  32'(M_AXIS_TVALID), 32'd0);
        check("reset tready", 32'(S_AXIS_TREADY), 32'd0);
        repeat (3) @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        #1;
        check("post-reset tready", 32'(S_AXIS_TREADY), 32'd1);

        // Three-Dword frame, downstream always ready
        q = '{32'h0000_0027, 32'h1234_5678, 32'hDEAD_BEEF};
        add_frame(q);
        run(0, 100, "frame3");
        idle(2, "frame3");

        // Single zero Dword frame
        q = '{32'h0000_0000};
        add_frame(q);
        run(0, 100, "frame1z");
        idle(2, "frame1z");

        // Same three-Dword frame under random backpressure and input gaps
        q = '{32'h0000_0027, 32'h1234_5678, 32'hDEAD_BEEF};
        add_frame(q);
        run(40, 50, "frame3rnd");
        idle(2, "frame3rnd");

        // Back-to-back frames of 2 and 5 random Dwords
        q.delete();
        repeat (2) q.push_back($urandom);
        add_frame(q);
        q.delete();
        repeat (5) q.push_back($urandom);
        add_frame(q);
        run(0, 100, "b2b");
        idle(2, "b2b");

        // Several random-length frames under random flow control
        for (int f = 0; f < 4; f++) begin
            q.delete();
            repeat ($urandom_range(1, 6)) q.push_back($urandom);
            add_frame(q);
        end
        run(30, 60, "rndframes");
        idle(2, "rndframes");

        // Reset mid-frame: two Dwords through, third held in the output stage
        q = '{$urandom, $urandom};
        in_q.push_back('{d: q[0], l: 1'b0});
        in_q.push_back('{d: q[1], l: 1'b0});
        exp_q.push_back('{d: q[0], l: 1'b0});
        exp_q.push_back('{d: q[1], l: 1'b0});
        run(0, 100, "midframe");
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = $urandom;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        @(negedge S_AXI_ACLK);
        check("midframe third loaded", 32'(M_AXIS_TVALID), 32'd1);
        S_AXI_ARESETN = 1'b0;
        #1;
        check("midframe reset valid",  32'(M_AXIS_TVALID), 32'd0);
        check("midframe reset tready", 32'(S_AXIS_TREADY), 32'd0);
        S_AXIS_TVALID = 1'b0;
        pending       = 1'b0;
        repeat (2) @(negedge S_AXI_ACLK);
        check("midframe held tready", 32'(S_AXIS_TREADY), 32'd0);
        S_AXI_ARESETN = 1'b1;
        q = '{32'hFFFF_FFFF};
        add_frame(q);
        run(0, 100, "afterreset");
        idle(3, "afterreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
